hazard_controller: RTL

//  Hazard/sequencing controller for the 5-stage pipelined ARM datapath. Drives the ForwardAE/ForwardBE

---
 rtl/hazard_controller.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// hazard_controller: forwarding, stall and flush control for the 5-stage
// pipelined ARM datapath. Keeps a private 3-stage shadow pipe that tracks
// in-flight PC writes, plus saturating debug counters for stall/flush events.
module hazard_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           RA1D,
  input  logic [3:0]           RA2D,
  input  logic [3:0]           RA1E,
  input  logic [3:0]           RA2E,
  input  logic [3:0]           WA3E,
  input  logic [3:0]           WA3M,
  input  logic [3:0]           WA3W,
  input  logic                 RegWriteE,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemtoRegE,
  input  logic                 PCSrcD,
  input  logic                 BranchTakenE,
  input  logic                 count_clear,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 PCSrcW,
  output logic [CNT_WIDTH-1:0] ldstall_cnt,
  output logic [CNT_WIDTH-1:0] pcwr_cnt,
  output logic [CNT_WIDTH-1:0] branch_cnt
);

  localparam logic [1:0] FWD_RD     = 2'b00;
  localparam logic [1:0] FWD_RESULT = 2'b01;
  localparam logic [1:0] FWD_ALUOUT = 2'b10;
  localparam logic [3:0] REG_PC     = 4'd15;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Shadow pipe: PC-write flag as it moves through Execute, Memory, Writeback.
  logic pcsE_r;
  logic pcsM_r;
  logic pcsW_r;

  // Event counters.
  logic [CNT_WIDTH-1:0] ldstallCnt_r;
  logic [CNT_WIDTH-1:0] pcwrCnt_r;
  logic [CNT_WIDTH-1:0] branchCnt_r;

  // Raw (ungated) hazard decisions.
  logic [1:0] fwdA_s;
  logic [1:0] fwdB_s;
  logic       ldStall_s;
  logic       pcwrPend_s;
  logic       stallF_s;
  logic       stallD_s;
  logic       flushD_s;
  logic       flushE_s;
  logic       pcwrEvent_s;

  // Forward select for one Execute source operand. The Memory stage holds the
  // younger result and wins; R15 is never forwarded because the register file
  // already supplies PC+8 for it.
  function automatic logic [1:0] fwdSel(
    input logic [3:0] ra,
    input logic       regWriteM,
    input logic [3:0] wa3M,
    input logic       regWriteW,
    input logic [3:0] wa3W
  );
    logic [1:0] sel;
    sel = FWD_RD;
    if (ra == REG_PC) begin
      sel = FWD_RD;
    end else if (regWriteM && (wa3M == ra)) begin
      sel = FWD_ALUOUT;
    end else if (regWriteW && (wa3W == ra)) begin
      sel = FWD_RESULT;
    end else begin
      sel = FWD_RD;
    end
    return sel;
  endfunction

  // Next value of a saturating event counter; clear beats increment.
  function automatic logic [CNT_WIDTH-1:0] cntNext(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 ev,
    input logic                 clr
  );
    logic [CNT_WIDTH-1:0] nxt;
    nxt = cnt;
    if (clr) begin
      nxt = CNT_ZERO;
    end else if (ev && (cnt != CNT_MAX)) begin
      nxt = cnt + CNT_ONE;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  // Hazard detection: forwarding, load-use stall and PC-write / branch flushes.
  always_comb begin
    fwdA_s      = FWD_RD;
    fwdB_s      = FWD_RD;
    ldStall_s   = 1'b0;
    pcwrPend_s  = 1'b0;
    stallF_s    = 1'b0;
    stallD_s    = 1'b0;
    flushD_s    = 1'b0;
    flushE_s    = 1'b0;
    pcwrEvent_s = 1'b0;

    fwdA_s = fwdSel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    fwdB_s = fwdSel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);

    // A taken branch squashes the Decode instruction anyway, so a load-use
    // stall on it would only waste a cycle.
    ldStall_s  = MemtoRegE && RegWriteE &&
                 ((RA1D == WA3E) || (RA2D == WA3E)) && !BranchTakenE;
    pcwrPend_s = PCSrcD || pcsE_r || pcsM_r;

    stallF_s    = ldStall_s || pcwrPend_s;
    stallD_s    = ldStall_s;
    flushD_s    = pcwrPend_s || pcsW_r || BranchTakenE;
    flushE_s    = ldStall_s || BranchTakenE;
    pcwrEvent_s = stallF_s && !ldStall_s;
  end

  // Output stage: every output reads zero while reset is held low.
  always_comb begin
    ForwardAE   = FWD_RD;
    ForwardBE   = FWD_RD;
    StallF      = 1'b0;
    StallD      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    PCSrcW      = 1'b0;
    ldstall_cnt = CNT_ZERO;
    pcwr_cnt    = CNT_ZERO;
    branch_cnt  = CNT_ZERO;
    if (reset) begin
      ForwardAE   = fwdA_s;
      ForwardBE   = fwdB_s;
      StallF      = stallF_s;
      StallD      = stallD_s;
      FlushD      = flushD_s;
      FlushE      = flushE_s;
      PCSrcW      = pcsW_r;
      ldstall_cnt = ldstallCnt_r;
      pcwr_cnt    = pcwrCnt_r;
      branch_cnt  = branchCnt_r;
    end else begin
      ForwardAE   = FWD_RD;
      ForwardBE   = FWD_RD;
      StallF      = 1'b0;
      StallD      = 1'b0;
      FlushD      = 1'b0;
      FlushE      = 1'b0;
      PCSrcW      = 1'b0;
      ldstall_cnt = CNT_ZERO;
      pcwr_cnt    = CNT_ZERO;
      branch_cnt  = CNT_ZERO;
    end
  end

  // Shadow pipe advance; a PC write held under a stall or squashed by a
  // branch (both raise FlushE) does not enter Execute.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcsE_r <= 1'b0;
      pcsM_r <= 1'b0;
      pcsW_r <= 1'b0;
    end else begin
      pcsE_r <= PCSrcD && !flushE_s;
      pcsM_r <= pcsE_r;
      pcsW_r <= pcsM_r;
    end
  end

  // Debug event counters, saturating at all-ones, with a synchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ldstallCnt_r <= CNT_ZERO;
      pcwrCnt_r    <= CNT_ZERO;
      branchCnt_r  <= CNT_ZERO;
    end else begin
      ldstallCnt_r <= cntNext(ldstallCnt_r, ldStall_s,    count_clear);
      pcwrCnt_r    <= cntNext(pcwrCnt_r,    pcwrEvent_s,  count_clear);
      branchCnt_r  <= cntNext(branchCnt_r,  BranchTakenE, count_clear);
    end
  end

endmodule
